// File: rtl/inst_encoder_pkg.sv
// Shared instruction-encoding definitions: format codes, RV32I opcodes, the NOP word
// and a signed-range helper for the field checks enabled by ENC_CHECK_EN.
package inst_encoder_pkg;

  typedef logic [3:0] fmt_t;

  localparam fmt_t FMT_R     = 4'd0;
  localparam fmt_t FMT_I     = 4'd1;
  localparam fmt_t FMT_IL    = 4'd2;
  localparam fmt_t FMT_S     = 4'd3;
  localparam fmt_t FMT_B     = 4'd4;
  localparam fmt_t FMT_JAL   = 4'd5;
  localparam fmt_t FMT_JALR  = 4'd6;
  localparam fmt_t FMT_LUI   = 4'd7;
  localparam fmt_t FMT_AUIPC = 4'd8;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IL    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int n);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (n - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational field-to-word encoder. With ENC_CHECK_EN the illegal flag
// reports unencodable fields; otherwise fields truncate and the flag is held low.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [3:0]  i_fmt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = NOP_WORD;
    o_illegal = 1'b0;
    case (i_fmt)
      FMT_R:     o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
      FMT_I:     o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
      FMT_IL:    o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IL};
      FMT_JALR:  o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_JALR};
      FMT_S:     o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_S};
      FMT_B:     o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], OP_B};
      FMT_JAL:   o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
      FMT_LUI:   o_word = {i_imm[31:12], i_rd, OP_LUI};
      FMT_AUIPC: o_word = {i_imm[31:12], i_rd, OP_AUIPC};
      default:   o_word = NOP_WORD;
    endcase
`ifdef ENC_CHECK_EN
    case (i_fmt)
      FMT_R:                         o_illegal = 1'b0;
      FMT_I, FMT_IL, FMT_JALR, FMT_S: o_illegal = !fits_signed(i_imm, 12);
      FMT_B:                         o_illegal = i_imm[0] || !fits_signed(i_imm, 13);
      FMT_JAL:                       o_illegal = i_imm[0] || !fits_signed(i_imm, 21);
      FMT_LUI, FMT_AUIPC:            o_illegal = |i_imm[11:0];
      default:                       o_illegal = 1'b1;
    endcase
`endif
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: streams encoded instructions into instruction memory from BASE.
// ENC_CHECK_EN enables field checking and the sticky err flag.
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   RUN    | accepting bundles, one word per cycle
//   HALT   | load complete (done high) until next start
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [3:0]    fmt,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [31:0]   imm,
  output logic          im_wena,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err
);

  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_RUN     = 2'd1;
  localparam logic [1:0]    S_HALT    = 2'd2;
  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW:0]   LAST_CNT  = {1'b0, {AW{1'b1}}};

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic          r_wena;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   w_word;
  logic          w_ill;
  logic          w_acc;
  logic          w_wr;
  logic          w_stop;

  inst_pack u_pack (
    .i_fmt     (fmt),
    .i_rd      (rd),
    .i_rs1     (rs1),
    .i_rs2     (rs2),
    .i_funct3  (funct3),
    .i_funct7  (funct7),
    .i_imm     (imm),
    .o_word    (w_word),
    .o_illegal (w_ill)
  );

  assign in_ready = (r_state == S_RUN) && !start;
  assign w_acc    = in_valid && in_ready;
  assign w_wr     = w_acc && !w_ill;
  // The word landing on the last address of the window ends the load; no wrap.
  assign w_stop   = w_acc && (in_last || (w_wr && (r_count == LAST_CNT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_wena  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_wena <= w_wr;
      if (w_wr) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
        r_ptr   <= r_ptr + AW'(1);
        r_count <= r_count + (AW+1)'(1);
      end
      if (start) begin
        r_ptr   <= BASE_ADDR;
        r_count <= '0;
      end
      case (r_state)
        S_IDLE:  if (start)  r_state <= S_RUN;
        S_RUN:   if (w_stop) r_state <= S_HALT;
        S_HALT:  if (start)  r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ENC_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_err <= 1'b0;
    else if (start)          r_err <= 1'b0;
    else if (w_acc && w_ill) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign im_wena  = r_wena;
  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign count    = r_count;
  assign done     = (r_state == S_HALT);

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, corner sequences and random
// traffic against a transaction-level model. Expectations follow ENC_CHECK_EN.
module tb_inst_encoder;

  typedef struct {
    logic [3:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  typedef struct {
    fld_t        f;
    bit          last;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st0 = 1'b0, st1 = 1'b0, vld0 = 1'b0, vld1 = 1'b0, in_last = 1'b0;
  logic [3:0]  fmt = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;

  logic        rdy0, wena0, done0, err0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic [8:0]  cnt0;
  logic        rdy1, wena1, done1, err1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;
  logic [2:0]  cnt1;

  int n_chk = 0;
  int n_err = 0;

  bit          m_run [2];
  bit          m_halt[2];
  int          m_cnt [2];
  bit          m_err [2];
  logic [31:0] last_wdata;
  logic [31:0] last_addr;

  always #5 clk = ~clk;

  inst_encoder #(.AW(8), .BASE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .in_valid(vld0), .in_ready(rdy0),
    .in_last(in_last), .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .im_wena(wena0), .im_addr(addr0), .im_wdata(wdata0),
    .count(cnt0), .done(done0), .err(err0)
  );

  inst_encoder #(.AW(2), .BASE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .in_valid(vld1), .in_ready(rdy1),
    .in_last(in_last), .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .im_wena(wena1), .im_addr(addr1), .im_wdata(wdata1),
    .count(cnt1), .done(done1), .err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic fld_t mk(input int f, input int d, input int s1, input int s2,
                              input int f3, input int f7, input logic [31:0] im);
    fld_t r;
    r.fmt = 4'(f); r.rd = 5'(d); r.rs1 = 5'(s1); r.rs2 = 5'(s2);
    r.f3 = 3'(f3); r.f7 = 7'(f7); r.imm = im;
    return r;
  endfunction

  // Reference encoder built from shifts and masks of the architectural fields.
  task automatic ref_encode(input fld_t f, output logic [31:0] w, output bit ill);
    logic [31:0] u;
    logic [31:0] regs;
    int s;
    u = f.imm;
    s = $signed(f.imm);
    regs = (32'(f.rs1) << 15) | (32'(f.f3) << 12);
    ill = 1'b0;
    case (int'(f.fmt))
      0: w = 32'h33 | (32'(f.rd) << 7) | regs | (32'(f.rs2) << 20) | (32'(f.f7) << 25);
      1, 2, 6: w = ((f.fmt == 1) ? 32'h13 : (f.fmt == 2) ? 32'h03 : 32'h67)
                   | (32'(f.rd) << 7) | regs | ((u & 32'hFFF) << 20);
      3: w = 32'h23 | ((u & 32'h1F) << 7) | regs | (32'(f.rs2) << 20)
             | (((u >> 5) & 32'h7F) << 25);
      4: w = 32'h63 | (((u >> 11) & 1) << 7) | (((u >> 1) & 32'hF) << 8) | regs
             | (32'(f.rs2) << 20) | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 1) << 31);
      5: w = 32'h6F | (32'(f.rd) << 7) | (((u >> 12) & 32'hFF) << 12)
             | (((u >> 11) & 1) << 20) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 1) << 31);
      7, 8: w = ((f.fmt == 7) ? 32'h37 : 32'h17) | (32'(f.rd) << 7) | (u & 32'hFFFFF000);
      default: w = 32'h00000013;
    endcase
`ifdef ENC_CHECK_EN
    case (int'(f.fmt))
      0:          ill = 1'b0;
      1, 2, 3, 6: ill = (s < -2048) || (s > 2047);
      4:          ill = (s < -4096) || (s > 4095) || u[0];
      5:          ill = (s < -1048576) || (s > 1048575) || u[0];
      7, 8:       ill = (u & 32'hFFF) != 0;
      default:    ill = 1'b1;
    endcase
`else
    ill = (s == 0) && 1'b0;
`endif
  endtask

  // One clock cycle on instance sel, checked against the model afterwards.
  task automatic step(input int sel, input bit st, input bit vld, input bit lst, input fld_t f);
    logic [31:0] ew;
    bit ill, er, acc, wr;
    int aw;
    @(negedge clk);
    st0 = (sel == 0) && st;  st1 = (sel == 1) && st;
    vld0 = (sel == 0) && vld; vld1 = (sel == 1) && vld;
    in_last = lst; fmt = f.fmt; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
    funct3 = f.f3; funct7 = f.f7; imm = f.imm;
    #1;
    er = m_run[sel] && !st;
    chk("in_ready", (sel == 1) ? 32'(rdy1) : 32'(rdy0), 32'(er));
    acc = vld && er;
    ref_encode(f, ew, ill);
    wr = acc && !ill;
    aw = (sel == 1) ? 2 : 8;
    @(posedge clk);
    #1;
    chk("im_wena", (sel == 1) ? 32'(wena1) : 32'(wena0), 32'(wr));
    if (wr) begin
      last_addr  = (sel == 1) ? 32'(addr1) : 32'(addr0);
      last_wdata = (sel == 1) ? wdata1 : wdata0;
      chk("im_addr", last_addr, 32'(m_cnt[sel] % (1 << aw)));
      chk("im_wdata", last_wdata, ew);
    end
    if (st) begin
      m_run[sel] = 1; m_halt[sel] = 0; m_cnt[sel] = 0; m_err[sel] = 0;
    end else if (acc) begin
      if (ill) m_err[sel] = 1;
      else     m_cnt[sel]++;
      if (lst || m_cnt[sel] == (1 << aw)) begin
        m_run[sel] = 0; m_halt[sel] = 1;
      end
    end
    chk("count", (sel == 1) ? 32'(cnt1) : 32'(cnt0), 32'(m_cnt[sel]));
    chk("done", (sel == 1) ? 32'(done1) : 32'(done0), 32'(m_halt[sel]));
    chk("err", (sel == 1) ? 32'(err1) : 32'(err0), 32'(m_err[sel]));
  endtask

  function automatic fld_t rnd_fld();
    fld_t f;
    int v;
    f.fmt = ($urandom_range(0, 99) < 8) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
    f.f3 = 3'($urandom); f.f7 = 7'($urandom); f.imm = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      case (int'(f.fmt))
        1, 2, 3, 6: begin v = int'($urandom_range(0, 4095)) - 2048; f.imm = v; end
        4: begin v = int'($urandom_range(0, 4095)) - 2048; f.imm = v * 2; end
        5: begin v = int'($urandom_range(0, 1048575)) - 524288; f.imm = v * 2; end
        7, 8: f.imm = $urandom & 32'hFFFFF000;
        default: ;
      endcase
    end
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_halt[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
    end
  endtask

  initial begin
    vec_t tbl[5];
    fld_t nopf;
    bit st, vld, lst;
    nopf = mk(1, 0, 0, 0, 0, 0, 32'h0);
    tbl[0] = '{f: mk(1, 1, 0, 0, 0, 0, 32'd5),          last: 1, exp: 32'h00500093};
    tbl[1] = '{f: mk(3, 0, 3, 2, 2, 0, 32'hFFFFFFFC),   last: 0, exp: 32'hFE21AE23};
    tbl[2] = '{f: mk(4, 0, 1, 2, 1, 0, 32'hFFFFFFF8),   last: 0, exp: 32'hFE209CE3};
    tbl[3] = '{f: mk(5, 1, 0, 0, 0, 0, 32'd2048),       last: 0, exp: 32'h001000EF};
    tbl[4] = '{f: mk(7, 5, 0, 0, 0, 0, 32'h12345000),   last: 1, exp: 32'h123452B7};
    model_reset();
    last_wdata = '0;
    last_addr = '0;

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(rdy0), 0);
    chk("rst im_wena", 32'(wena0), 0);
    chk("rst im_addr", 32'(addr0), 0);
    chk("rst im_wdata", wdata0, 0);
    chk("rst count", 32'(cnt0), 0);
    chk("rst done", 32'(done0), 0);
    chk("rst err", 32'(err0), 0);
    chk("rst done1", 32'(done1), 0);
    chk("rst count1", 32'(cnt1), 0);
    rst_n = 1'b1;

    // Directed encoding vectors, back-to-back within a load.
    for (int i = 0; i < 5; i++) begin
      if (!m_run[0]) step(0, 1, 0, 0, nopf);
      step(0, 0, 1, tbl[i].last, tbl[i].f);
      chk("vec_wdata", last_wdata, tbl[i].exp);
    end

    // Start while RUN at address 3: bundle refused, next word lands at BASE.
    step(0, 1, 0, 0, nopf);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, mk(0, i, 1, 2, 3, 4, 0));
    step(0, 1, 1, 0, mk(1, 7, 7, 0, 0, 0, 32'd9));
    step(0, 0, 1, 0, mk(1, 8, 8, 0, 0, 0, 32'd10));
    chk("restart_addr", last_addr, 0);

    // Illegal format and misaligned branch offset.
    step(0, 1, 0, 0, nopf);
    step(0, 0, 1, 0, mk(12, 3, 4, 5, 1, 0, 32'd1));
    step(0, 0, 1, 0, mk(4, 0, 1, 2, 0, 0, 32'd3));
    step(0, 0, 1, 1, mk(1, 2, 0, 0, 0, 0, 32'd1));
`ifdef ENC_CHECK_EN
    chk("chk_err", 32'(err0), 1);
    chk("chk_count", 32'(cnt0), 1);
`else
    chk("nochk_err", 32'(err0), 0);
    chk("nochk_count", 32'(cnt0), 3);
`endif

    // AW=2 window fills after four words; the fifth is refused.
    step(1, 1, 0, 0, nopf);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, mk(0, i, i, i, 0, 0, 0));
    chk("full_done", 32'(done1), 1);
    chk("full_count", 32'(cnt1), 4);

    // Reset with a write registered drops it immediately.
    step(0, 1, 0, 0, nopf);
    @(negedge clk);
    st0 = 0; vld0 = 1; in_last = 0; fmt = 4'd1; imm = 32'd1;
    @(posedge clk);
    #1;
    chk("pre_rst_wena", 32'(wena0), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_wena", 32'(wena0), 0);
    chk("rst_drop_count", 32'(cnt0), 0);
    chk("rst_drop_ready", 32'(rdy0), 0);
    @(negedge clk);
    vld0 = 0;
    rst_n = 1'b1;
    model_reset();

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 24) == 0) || (!m_run[0] && $urandom_range(0, 2) == 0);
      vld = $urandom_range(0, 9) < 7;
      lst = $urandom_range(0, 19) == 0;
      step(0, st, vld, lst, rnd_fld());
    end
    for (int i = 0; i < 150; i++) begin
      st  = ($urandom_range(0, 29) == 0) || (!m_run[1] && $urandom_range(0, 2) == 0);
      vld = $urandom_range(0, 9) < 8;
      lst = $urandom_range(0, 39) == 0;
      step(1, st, vld, lst, rnd_fld());
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter AW, default 8: instruction-memory word-address width.
REQ-002 SHALL have parameter BASE, default 0: first write address after start.
REQ-003 SHALL have clock and reset as follows: one clock; reset is asynchronous and active-low. Ports: clk, rst_n.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port start: input, 1 bit, one-cycle pulse that begins or restarts a program load.
REQ-007 Port in_valid: input, 1 bit, field bundle valid.
REQ-008 Port in_ready: output, 1 bit, bundle accepted when in_valid and in_ready are both high.
REQ-009 Port in_last: input, 1 bit, marks the final instruction of the program.
REQ-010 Port fmt: input, 4 bits. 0=R, 1=I, 2=IL, 3=S, 4=B, 5=JAL, 6=JALR, 7=LUI, 8=AUIPC; 9-15 illegal.
REQ-011 Instruction field ports, all inputs:
- rd, rs1, rs2: 5 bits each.
- funct3: 3 bits.
- funct7: 7 bits.
- imm: 32 bits, signed.
REQ-012 Port im_wena: output, 1 bit, instruction-memory write enable.
REQ-013 Port im_addr: output, AW bits, write address.
REQ-014 Port im_wdata: output, 32 bits, encoded instruction.
REQ-015 Port count: output, AW+1 bits, number of words written since start.
REQ-016 Port done: output, 1 bit, program load complete.
REQ-017 Port err: output, 1 bit, sticky encode error.

Function
REQ-018 SHALL implement a state machine with states IDLE, RUN and HALT.
- IDLE to RUN on start.
- RUN to HALT when an in_last bundle is accepted, or when the word at address BASE+2^AW-1 is accepted.
- HALT to RUN on start.
REQ-019 in_ready SHALL be high only when state is RUN and start is low; throughput SHALL be one bundle per cycle.
REQ-020 A bundle accepted in cycle N SHALL produce im_wena=1 in cycle N+1, with im_addr equal to the write pointer and im_wdata registered.
REQ-021 The write pointer and count SHALL increment on each accepted word; on start they SHALL load BASE and 0.
REQ-022 Opcodes SHALL be: R 0110011, I 0010011, IL 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-023 Bit layouts SHALL be:
- R: funct7|rs2|rs1|funct3|rd|op.
- I/IL/JALR: imm[11:0]|rs1|funct3|rd|op.
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
- LUI/AUIPC: imm[31:12]|rd|op.
- JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-024 done SHALL be high throughout HALT, asserting in the same cycle as the final im_wena; start in HALT SHALL clear done next cycle.
REQ-025 A start in RUN SHALL abort the load and restart at BASE; a write already registered SHALL still complete at its original address.
REQ-026 A pointer wrap past BASE+2^AW-1 SHALL NOT occur.

Reset
REQ-027 While rst_n is low, state SHALL be IDLE, and in_ready, im_wena, done, err SHALL be 0; im_addr, im_wdata and count SHALL be 0.
REQ-028 Reset mid-load SHALL drop any pending write.

Configuration
REQ-029 With ENC_CHECK_EN defined, the following SHALL each set err and be accepted but not written, with no pointer advance:
- illegal fmt;
- B/JAL imm[0]=1;
- imm outside the signed field range (12/13/21 bits);
- LUI/AUIPC imm[11:0]≠0.
err SHALL clear only on start or reset.
REQ-030 Without ENC_CHECK_EN, fields SHALL be truncated silently, illegal fmt SHALL encode 32'h00000013 (NOP), and err SHALL be tied 0.

Structure
REQ-031 The fmt codes, the opcode constants and the NOP word SHALL live in the shared define package alongside the existing opcode macros.
REQ-032 Encoding SHALL be one combinational sub-module, inst_pack (fields in, 32-bit word and illegal flag out); inst_encoder holds the FSM, pointer and output registers.

Verification
REQ-033 Reset then start; send I addi with rd=1, rs1=0, f3=0, imm=5, in_last=1 -> im_wena at N+1, im_addr=0, im_wdata=32'h00500093, done=1, count=1.
REQ-034 Send back-to-back S (imm=-4, rs2=2, rs1=3, f3=2) then B (imm=-8, rs1=1, rs2=2, f3=1) -> addresses 0, 1 on consecutive cycles; data 32'hFE21AE23, then 32'hFE209CE3.
REQ-035 Send JAL (rd=1, imm=2048), then LUI (rd=5, imm=32'h12345000) -> data 32'h001000EF, then 32'h123452B7.
REQ-036 AW=2: stream 5 bundles without in_last -> 4 writes, HALT after the 4th, in_ready low for the 5th, done=1.
REQ-037 Assert start concurrent with in_valid in RUN at address 3 -> that bundle is not accepted, and the next accepted word is written at BASE.
REQ-038 Send fmt=12, and B with imm=3 -> with ENC_CHECK_EN, err=1 and no writes; without it, NOP is written for fmt=12 and err=0.
